// File: rtl/serial_sub_8_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the bit-counter width.
package serial_sub_8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CW        = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_8_fadder.sv
// One-bit full adder cell; the subtractor feeds it an inverted subtrahend bit
// and an inverted borrow so that carry-out is the complement of borrow-out.
module fadder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial two's-complement subtractor d = a - b - bin, LSB first, one bit
// per clock through a single full-adder cell.
//
//   state | meaning
//   IDLE  | waiting for start; results from the last operation are held
//   RUN   | one result bit per cycle, bit index = cnt
//   DONE  | single-cycle done pulse; start is accepted here as in IDLE
module serial_sub_8
  import serial_sub_8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CNTW = cnt_width(WIDTH);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t state, state_n;

  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] acc;
  logic             br;

  logic             accept;
  logic             last;
  logic             a_i;
  logic             b_i;
  logic             sum;
  logic             co;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  assign a_i     = a_sr[0];
  assign b_i     = b_sr[0];
  assign last    = (cnt == LAST_BIT);
  assign br_next = ~co;
  // Partial result with the current bit on top; aligned once the last bit lands.
  assign d_next  = {sum, acc};

  fadder u_fadder (
    .x  (a_i),
    .y  (~b_i),
    .ci (~br),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      a_sr <= '0;
      b_sr <= '0;
      acc  <= '0;
      br   <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
    end else if (state == RUN) begin
      cnt  <= cnt + 1'b1;
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_next;
      acc  <= d_next[WIDTH-1:1];
      if (last) begin
        // a_i/b_i/sum are the MSBs here, which is all the overflow test needs.
        d    <= d_next;
        bout <= br_next;
        zero <= (d_next == '0);
        ovf  <= (a_i ^ b_i) & (sum ^ a_i);
      end
    end
  end

endmodule

// File: doc/serial_sub_8.md
Name: serial_sub_8

Overview:
Bit-serial two's-complement subtractor: computes d = a - b - bin one bit per clock, LSB first, using a single full-adder cell in subtract mode. It is the subtract-direction counterpart of the 8-bit ripple adder. It trades seven adder cells for WIDTH cycles of latency. A start/busy/done handshake lets a sequencer or testbench issue operations.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new subtraction; sampled only when not busy
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result is valid
d  output  WIDTH  difference, held stable from done until next accepted start
bout  output  1  borrow out (1 when a < b + bin, unsigned)
zero  output  1  1 when d == 0
ovf  output  1  signed overflow: a[MSB] != b[MSB] and d[MSB] != a[MSB]

Behaviour:
- Reset: clk edge with rst=1 forces state IDLE. Bit counter, operand shift registers, borrow flop, d, bout, zero, ovf, busy and done all go to 0. rst has priority over start. Reset in RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b, bin, clears the counter, sets busy=1 and moves to RUN. The latched bin becomes the initial borrow.
- RUN: each cycle processes bit i = counter, i.e. WIDTH cycles for bits 0..WIDTH-1.
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Implementation: full adder on a_i, ~b_i, carry-in ~br; br_next = ~carry-out.
  - Result bits shift into d MSB-first position so that d is correctly aligned after WIDTH cycles.
  - On the last bit (counter == WIDTH-1): bout <= br_next; zero and ovf are computed from the final d; busy <= 0; done <= 1; state goes to DONE.
- Latency: start accepted at edge N; done is high in the cycle after edge N+WIDTH (for WIDTH=8, done follows the 8th RUN edge).
- DONE: lasts exactly one cycle with done=1, then returns to IDLE with done=0. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle bubble).
- start while busy=1 is ignored. Operands and inputs changing during RUN have no effect.
- d, bout, zero and ovf hold their last values through IDLE. They update only at RUN completion. They are not cleared by a new start; intermediate shift contents are internal only.
- Wrap-around is modulo 2^WIDTH, e.g. 0 - 1 = all ones with bout=1.

Decomposition:
- Shared package / include holds WIDTH default, the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and counter width CW = clog2(WIDTH).
- One sub-module: the existing 1-bit full adder cell fadder, instantiated once with b bit inverted and carry-in = ~borrow. Everything else is in serial_sub_8.

Test Plan:
1. a=8'd5, b=8'd3, bin=0, start one cycle -> busy for 8 cycles, done pulse after 8th edge, d=8'h02, bout=0, zero=0, ovf=0.
2. a=8'd3, b=8'd5, bin=0 -> d=8'hFE, bout=1, zero=0, ovf=0.
3. a=8'h80, b=8'h01, bin=0 -> d=8'h7F, bout=0, ovf=1; then a=8'h7F, b=8'hFF -> d=8'h80, bout=1, ovf=1.
4. a=8'h00, b=8'h00, bin=1 -> d=8'hFF, bout=1; then a=8'h2A, b=8'h2A, bin=0 -> d=8'h00, zero=1, bout=0.
5. Handshake: start with a=9, b=4, then at RUN cycle 3 pulse start with a=1, b=1 -> ignored, d=8'h05. Assert start in the DONE cycle with a=8'h10, b=8'h01 -> accepted, next done gives d=8'h0F.
6. rst=1 at RUN cycle 4 (start had rst=0) -> next cycle busy=0, done=0, d=0, bout=0, and no done pulse afterwards. A new start then completes normally.
